fft_butterfly_pipe: RTL
=======================

# fft_butterfly_pipe

Pipelined radix-2 DIF butterfly for the FFT datapath: from complex inputs a and b and a twiddle W it produces the sum a+b and the twiddled difference (b−a)·W. Fixed-point format, rounding and saturation are set by parameters. The block has a valid/ready handshake on both sides, so it can be stalled by a downstream memory write-back. It sits between the sample-buffer read port and the FFT stage controller.

## Interface
- DW, 32: data and coefficient width, signed two's complement.
- FRAC, 16: fractional bits of the twiddle (1.0 = 2^FRAC).
- ROUND, 1: 1 = round half up (add 2^(FRAC−1), then arithmetic shift); 0 = floor (arithmetic shift only).
- SAT, 1: 1 = saturate results to DW bits; 0 = wrap (keep low DW bits).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- real_a, imag_a  in  DW  operand a.
- real_b, imag_b  in  DW  operand b.
- real_coff, imag_coff  in  DW  twiddle W, Q(DW−FRAC).FRAC.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- sum_real, sum_imag  out  DW  a+b.
- diff_real, diff_imag  out  DW  (b−a)·W.
- ovf  out  1  saturation or wrap occurred on this output sample.
- ovf_sticky  out  1  OR of ovf over all accepted outputs since the last reset or clear.
- clr_ovf  in  1  clears ovf_sticky.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Differences are DW+1 bits: dr = b_r−a_r, di = b_i−a_i.
- Products are 2DW+1 bits: dr·Cr, di·Ci, dr·Ci, di·Cr.
- Accumulators are 2DW+2 bits:
  - re = dr·Cr − di·Ci
  - im = dr·Ci + di·Cr
- Diff output: each accumulator is rounded per ROUND, arithmetic-shifted right by FRAC, then reduced to DW bits per SAT.
- Sum path: a+b computed at DW+1 bits, reduced to DW bits per SAT. No scaling, no rounding.
- Saturation range is [−2^(DW−1), 2^(DW−1)−1].
- ovf is set if any of the four results fell outside that range, whether SAT=1 or SAT=0.
- ovf_sticky:
  - Set on any output transfer with ovf=1.
  - Cleared by clr_ovf.
  - If clr_ovf and a transfer with ovf=1 occur in the same cycle, the set wins.
- Ordering: strictly in order; no sample is dropped or duplicated.

## Timing
- Three register stages, each with its own valid bit:
  - S1: differences, sums, coefficients.
  - S2: the four products, plus the sums carried forward.
  - S3: rounded, saturated outputs and ovf; these are the output registers.
- Latency: 3 cycles from input transfer to out_valid when not stalled. Throughput is 1 sample per cycle.
- Stage advance rule:
  - S3 loads when it is empty or out_ready=1.
  - Sk loads when Sk is empty or S(k+1) loads.
  - in_ready = S1 loads.
  - in_ready is combinational from out_ready and the stage valid bits.
  - in_ready has no dependence on in_valid.
- Bubbles collapse. With out_ready held low, exactly 3 samples are accepted before in_ready drops.
- While out_valid=1 && out_ready=0, all outputs hold stable.
- Reset (synchronous): all valid bits, out_valid, ovf, ovf_sticky and all data outputs go to 0. Any samples in flight are discarded. in_ready is 1 in the first cycle after reset.
- rst has priority over every other input in the same cycle.

## Structure
- Package fft_pkg holds:
  - Width localparams derived from DW: DIFF_W = DW+1, PROD_W = 2DW+1, ACC_W = 2DW+2.
  - A function that reduces a wide value to DW bits and returns the overflow bit (round/shift/saturate-or-wrap).
- Sub-module fft_round_sat: combinational, parameters DW, FRAC, ROUND, SAT, input width. Four instances: diff_real, diff_imag, and the two sums with FRAC=0 and ROUND=0.
- Top level holds only the pipeline registers, the valid/ready logic and the sticky flag.

## Test plan
All cases use DW=32, FRAC=16, out_ready=1 unless stated.
- Identity twiddle: a=(0,0), b=(3,5), W=(65536,0) → 3 cycles later diff=(3,5), sum=(3,5), ovf=0.
- Quarter turn: a=(1,1), b=(4,6), W=(0,65536) → diff=(−5,3), sum=(5,7).
- Rounding with b−a=(1,0):
  - W=(32768,0) → diff_real=1 with ROUND=1; 0 with ROUND=0.
  - b−a=(−1,0), same W → 0 with ROUND=1; −1 with ROUND=0.
- Overflow: a=(−2^31,0), b=(2^31−1,0), W=(65536,0):
  - SAT=1 → diff_real=0x7FFFFFFF, ovf=1, ovf_sticky=1, sum_real=−1.
  - SAT=0 → diff_real=0xFFFFFFFF, ovf=1.
  - Then clr_ovf → ovf_sticky=0.
- Backpressure: stream 6 samples with out_ready=0 for 5 cycles:
  - in_ready drops after exactly 3 accepts.
  - Outputs are held stable while stalled.
  - All 6 results appear in order once out_ready=1, with no gaps.
- Reset mid-stream: assert rst with 2 samples in flight → next cycle out_valid=0, ovf_sticky=0, in_ready=1, and no stale output appears afterwards.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths and the round/shift/saturate reduction used by the FFT butterfly.
// The reduction runs on a fixed wide container so one function serves every operand width.
package fft_pkg;

  localparam int FFT_DW = 32;
  localparam int MAX_W  = 136;

  function automatic int diff_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int prod_w(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int acc_w(input int dw);
    return 2 * dw + 2;
  endfunction

  localparam int DIFF_W = diff_w(FFT_DW);
  localparam int PROD_W = prod_w(FFT_DW);
  localparam int ACC_W  = acc_w(FFT_DW);

  typedef struct packed {
    logic signed [MAX_W-1:0] y;
    logic                    ovf;
  } red_t;

  // Round (half up) or floor, shift by frac, then clamp or wrap to dw bits.
  // ovf reports an out-of-range result regardless of clamp/wrap.
  function automatic red_t reduce(input logic signed [MAX_W-1:0] x, input int dw,
                                  input int frac, input int rnd, input int sat);
    logic signed [MAX_W-1:0] one, t, hi, lo;
    red_t r;
    one    = '0;
    one[0] = 1'b1;
    t      = x;
    if (rnd != 0 && frac > 0) t = t + (one <<< (frac - 1));
    t  = t >>> frac;
    hi = (one <<< (dw - 1)) - one;
    lo = -hi - one;
    r.ovf = (t > hi) || (t < lo);
    if (sat != 0 && t > hi)      r.y = hi;
    else if (sat != 0 && t < lo) r.y = lo;
    else                         r.y = (t <<< (MAX_W - dw)) >>> (MAX_W - dw);
    return r;
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Combinational reduction of a wide signed value to DW bits with an overflow flag.
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1,
  parameter int IN_W  = 66
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [DW-1:0]   dout,
  output logic                   ovf
);

  logic signed [MAX_W-1:0] ext;
  red_t                    r;
  logic                    unused_hi;

  assign ext       = $signed({{(MAX_W-IN_W){din[IN_W-1]}}, din});
  assign r         = reduce(ext, DW, FRAC, ROUND, SAT);
  assign dout      = r.y[DW-1:0];
  assign ovf       = r.ovf;
  assign unused_hi = ^r.y[MAX_W-1:DW];

endmodule

// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 DIF butterfly: sum = a+b, diff = (b-a)*W, with valid/ready
// backpressure and collapsing bubbles.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] real_a,
  input  logic signed [DW-1:0] imag_a,
  input  logic signed [DW-1:0] real_b,
  input  logic signed [DW-1:0] imag_b,
  input  logic signed [DW-1:0] real_coff,
  input  logic signed [DW-1:0] imag_coff,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] sum_real,
  output logic signed [DW-1:0] sum_imag,
  output logic signed [DW-1:0] diff_real,
  output logic signed [DW-1:0] diff_imag,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 clr_ovf
);

  localparam int DW_DIFF = diff_w(DW);
  localparam int DW_PROD = prod_w(DW);
  localparam int DW_ACC  = acc_w(DW);

  logic                      vld_p1, vld_p2, vld_p3;
  logic                      ld1, ld2, ld3;
  logic signed [DW_DIFF-1:0] dr_p1, di_p1, sr_p1, si_p1;
  logic signed [DW-1:0]      cr_p1, ci_p1;
  logic signed [DW_PROD-1:0] dr_x, di_x, cr_x, ci_x;
  logic signed [DW_PROD-1:0] prr_p2, pii_p2, pri_p2, pir_p2;
  logic signed [DW_DIFF-1:0] sr_p2, si_p2;
  logic signed [DW_ACC-1:0]  acc_re, acc_im;
  logic signed [DW-1:0]      dre_n, dim_n, sre_n, sim_n;
  logic                      o_dre, o_dim, o_sre, o_sim;

  // Each stage advances when it is empty or the stage after it advances.
  assign ld3       = !vld_p3 || out_ready;
  assign ld2       = !vld_p2 || ld3;
  assign ld1       = !vld_p1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      sum_real   <= '0;
      sum_imag   <= '0;
      diff_real  <= '0;
      diff_imag  <= '0;
    end else begin
      if (ld1) vld_p1 <= in_valid;
      if (ld2) vld_p2 <= vld_p1;
      if (ld3) begin
        vld_p3 <= vld_p2;
        // S3: output registers
        if (vld_p2) begin
          sum_real  <= sre_n;
          sum_imag  <= sim_n;
          diff_real <= dre_n;
          diff_imag <= dim_n;
          ovf       <= o_dre | o_dim | o_sre | o_sim;
        end
      end
      if (vld_p3 && out_ready && ovf) ovf_sticky <= 1'b1;
      else if (clr_ovf)               ovf_sticky <= 1'b0;
    end
  end

  // S1: differences, sums and coefficients
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      dr_p1 <= $signed({real_b[DW-1], real_b}) - $signed({real_a[DW-1], real_a});
      di_p1 <= $signed({imag_b[DW-1], imag_b}) - $signed({imag_a[DW-1], imag_a});
      sr_p1 <= $signed({real_a[DW-1], real_a}) + $signed({real_b[DW-1], real_b});
      si_p1 <= $signed({imag_a[DW-1], imag_a}) + $signed({imag_b[DW-1], imag_b});
      cr_p1 <= real_coff;
      ci_p1 <= imag_coff;
    end
  end

  assign dr_x = $signed({{(DW_PROD-DW_DIFF){dr_p1[DW_DIFF-1]}}, dr_p1});
  assign di_x = $signed({{(DW_PROD-DW_DIFF){di_p1[DW_DIFF-1]}}, di_p1});
  assign cr_x = $signed({{(DW_PROD-DW){cr_p1[DW-1]}}, cr_p1});
  assign ci_x = $signed({{(DW_PROD-DW){ci_p1[DW-1]}}, ci_p1});

  // S2: the four partial products, sums carried along
  always_ff @(posedge clk) begin
    if (ld2 && vld_p1) begin
      prr_p2 <= dr_x * cr_x;
      pii_p2 <= di_x * ci_x;
      pri_p2 <= dr_x * ci_x;
      pir_p2 <= di_x * cr_x;
      sr_p2  <= sr_p1;
      si_p2  <= si_p1;
    end
  end

  assign acc_re = $signed({prr_p2[DW_PROD-1], prr_p2}) - $signed({pii_p2[DW_PROD-1], pii_p2});
  assign acc_im = $signed({pri_p2[DW_PROD-1], pri_p2}) + $signed({pir_p2[DW_PROD-1], pir_p2});

  fft_round_sat #(.DW(DW), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT), .IN_W(DW_ACC)) u_rs_dre (
    .din(acc_re), .dout(dre_n), .ovf(o_dre)
  );

  fft_round_sat #(.DW(DW), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT), .IN_W(DW_ACC)) u_rs_dim (
    .din(acc_im), .dout(dim_n), .ovf(o_dim)
  );

  fft_round_sat #(.DW(DW), .FRAC(0), .ROUND(0), .SAT(SAT), .IN_W(DW_DIFF)) u_rs_sre (
    .din(sr_p2), .dout(sre_n), .ovf(o_sre)
  );

  fft_round_sat #(.DW(DW), .FRAC(0), .ROUND(0), .SAT(SAT), .IN_W(DW_DIFF)) u_rs_sim (
    .din(si_p2), .dout(sim_n), .ovf(o_sim)
  );

endmodule
